// File: rtl/aes_sched_pkg.sv
// Shared widths and scheduler state encoding for the AES job scheduler.
package aes_sched_pkg;
  localparam int KEY_W  = 256;
  localparam int BLK_W  = 128;
  localparam int SEED_W = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REKEY,
    S_RUN,
    S_RESP
  } sched_state_t;
endpackage

// File: rtl/aes_job_scheduler_rr_arbiter.sv
// Pointer-based round-robin arbiter: one-hot grant searched upward from ptr with wrap.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  logic [IW-1:0] ptr;
  logic [IW:0]   pos;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (IW+1)'(i);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (!found && req[pos[IW-1:0]]) begin
        found                 = 1'b1;
        grant[pos[IW-1:0]]    = 1'b1;
        grant_idx             = pos[IW-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it gets lowest priority next round.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr <= '0;
    else if (accept) ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/aes_job_scheduler.sv
// Shares one AES256 core among N_REQ requesters: key/seed load, RR grant, watchdog, response.
module aes_job_scheduler
  import aes_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 64,
  parameter int IDW     = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [KEY_W-1:0]       cfg_key,
  input  logic [SEED_W-1:0]      cfg_seed,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [BLK_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]       req_dec,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [BLK_W-1:0]       rsp_data,
  output logic [IDW-1:0]         rsp_id,
  output logic                   rsp_err,
  output logic [KEY_W-1:0]       core_key,
  output logic [SEED_W-1:0]      core_sbox_seed,
  output logic [BLK_W-1:0]       core_data_in,
  output logic                   core_start,
  output logic                   core_rekey,
  output logic                   core_dec,
  input  logic                   core_done,
  input  logic [BLK_W-1:0]       core_data_out_enc,
  input  logic [BLK_W-1:0]       core_data_out_dec
);
  localparam int WDW = $clog2(TIMEOUT + 1);

  sched_state_t state, state_nx;

  logic [N_REQ-1:0]            grant;
  logic [IDW-1:0]              grant_idx;
  logic [N_REQ-1:0][BLK_W-1:0] req_blk;
  logic [WDW-1:0]              wdog;
  logic                        key_ok, grant_en, cfg_take, req_take, wd_expire;

  assign req_blk   = req_data;
  assign wd_expire = (wdog == WDW'(TIMEOUT - 1));
  assign req_ready = grant_en ? grant : '0;
  assign rsp_valid = (state == S_RESP);

  rr_arbiter #(.N(N_REQ), .IW(IDW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (req_take),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // cfg_ready is gated by rst so the handshake reads 0 while reset is held.
  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    grant_en  = 1'b0;
    cfg_take  = 1'b0;
    req_take  = 1'b0;
    case (state)
      S_IDLE: begin
        cfg_ready = rst;
        grant_en  = key_ok && !cfg_valid;
        if (cfg_valid) begin
          cfg_take = 1'b1;
          state_nx = S_REKEY;
        end else if (grant_en && |req_valid) begin
          req_take = 1'b1;
          state_nx = S_RUN;
        end
      end
      S_REKEY: if (core_done || wd_expire) state_nx = S_IDLE;
      S_RUN:   if (core_done || wd_expire) state_nx = S_RESP;
      S_RESP:  if (rsp_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_start     <= 1'b0;
      core_rekey     <= 1'b0;
      core_key       <= '0;
      core_sbox_seed <= '0;
      core_data_in   <= '0;
      core_dec       <= 1'b0;
      rsp_id         <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      key_ok         <= 1'b0;
      wdog           <= '0;
    end else begin
      core_start <= req_take;
      core_rekey <= cfg_take;
      if (cfg_take) begin
        core_key       <= cfg_key;
        core_sbox_seed <= cfg_seed;
      end
      if (req_take) begin
        core_data_in <= req_blk[grant_idx];
        core_dec     <= req_dec[grant_idx];
        rsp_id       <= grant_idx;
      end
      // Watchdog counts pulse-cycle as 0; expiry on TIMEOUT-1 puts RESP exactly TIMEOUT after start.
      if (cfg_take || req_take)
        wdog <= '0;
      else if ((state == S_REKEY || state == S_RUN) && !wd_expire)
        wdog <= wdog + 1'b1;
      if (state == S_REKEY) begin
        if (core_done)      key_ok <= 1'b1;
        else if (wd_expire) key_ok <= 1'b0;
      end
      if (state == S_RUN) begin
        if (core_done) begin
          rsp_data <= core_dec ? core_data_out_dec : core_data_out_enc;
          rsp_err  <= 1'b0;
        end else if (wd_expire) begin
          rsp_data <= '0;
          rsp_err  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_job_scheduler.sv
// Directed bench for aes_job_scheduler with a transaction-level model checked every cycle.
module tb_aes_job_scheduler;
  localparam int N_REQ   = 2;
  localparam int TIMEOUT = 64;
  localparam int IDW     = $clog2(N_REQ);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               cfg_valid, cfg_ready;
  logic [255:0]       cfg_key, cfg_seed;
  logic [N_REQ-1:0]   req_valid, req_ready, req_dec;
  logic [128*N_REQ-1:0] req_data;
  logic               rsp_valid, rsp_ready, rsp_err;
  logic [127:0]       rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic [255:0]       core_key, core_sbox_seed;
  logic [127:0]       core_data_in, core_data_out_enc, core_data_out_dec;
  logic               core_start, core_rekey, core_dec, core_done;

  aes_job_scheduler #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_seed(cfg_seed),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_dec(req_dec),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .core_key(core_key), .core_sbox_seed(core_sbox_seed), .core_data_in(core_data_in),
    .core_start(core_start), .core_rekey(core_rekey), .core_dec(core_dec),
    .core_done(core_done), .core_data_out_enc(core_data_out_enc), .core_data_out_dec(core_data_out_dec)
  );

  // Core stand-in: done arrives lat cycles after the pulse (0 = same cycle, -1 = never).
  int           lat = -1;
  logic [127:0] enc_mask = '0, dec_mask = '0;
  logic [7:0]   core_age = '0;
  always @(posedge clk)
    if (core_start || core_rekey)             core_age <= 8'd1;
    else if (core_age != 0 && core_age != 8'hFF) core_age <= core_age + 8'd1;
  assign core_done = (lat >= 0) && ((core_start || core_rekey) ? (lat == 0)
                                   : (core_age != 0 && int'(core_age) == lat));
  assign core_data_out_enc = core_data_in ^ enc_mask;
  assign core_data_out_dec = core_data_in ^ dec_mask;

  int n_tests = 0, n_fail = 0, cyc = 0, start_cnt = 0, rekey_cnt = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expired(string name);
    n_tests++; n_fail++;
    $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
  endtask

  function automatic int rr_pick(logic [N_REQ-1:0] v, int p);
    for (int i = 0; i < N_REQ; i++)
      if (v[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return -1;
  endfunction

  // Model: phase 0 idle, 1 rekeying, 2 job in core, 3 holding response.
  int           m_phase = 0, m_age = 0, m_ptr = 0, m_jid = 0;
  bit           m_key_ok = 0, m_jdec = 0, m_rerr = 0;
  logic [255:0] m_key = '0, m_seed = '0;
  logic [127:0] m_jdata = '0, m_rdata = '0;
  int           log_id[$];
  logic [127:0] log_data[$];

  always @(negedge clk) begin
    int w;
    logic [N_REQ-1:0] exp_rdy;
    if (core_start) start_cnt++;
    if (core_rekey) rekey_cnt++;
    if (!rst) begin
      m_phase = 0; m_age = 0; m_ptr = 0; m_key_ok = 0; m_key = '0; m_seed = '0;
      chk("rst_cfg_ready", cfg_ready, 0);   chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);   chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_id", rsp_id, 0);         chk("rst_rsp_err", rsp_err, 0);
      chk("rst_core_start", core_start, 0); chk("rst_core_rekey", core_rekey, 0);
      chk("rst_core_key", core_key, 0);     chk("rst_core_seed", core_sbox_seed, 0);
      chk("rst_core_data_in", core_data_in, 0); chk("rst_core_dec", core_dec, 0);
    end else begin
      w = rr_pick(req_valid, m_ptr);
      exp_rdy = (m_phase == 0 && m_key_ok && !cfg_valid && w >= 0) ? N_REQ'(1) << w : '0;
      chk("cfg_ready", cfg_ready, m_phase == 0);
      chk("req_ready", req_ready, exp_rdy);
      chk("core_start", core_start, m_phase == 2 && m_age == 0);
      chk("core_rekey", core_rekey, m_phase == 1 && m_age == 0);
      chk("core_key", core_key, m_key);
      chk("core_seed", core_sbox_seed, m_seed);
      chk("rsp_valid", rsp_valid, m_phase == 3);
      if (m_phase == 2) begin
        chk("core_data_in", core_data_in, m_jdata);
        chk("core_dec", core_dec, m_jdec);
      end
      if (m_phase == 3) begin
        chk("rsp_data", rsp_data, m_rdata);
        chk("rsp_id", rsp_id, m_jid);
        chk("rsp_err", rsp_err, m_rerr);
      end
      case (m_phase)
        0: if (cfg_valid) begin
             m_key = cfg_key; m_seed = cfg_seed; m_phase = 1; m_age = 0;
           end else if (m_key_ok && w >= 0) begin
             m_jid = w; m_jdata = req_data[w*128 +: 128]; m_jdec = req_dec[w];
             m_ptr = (w + 1) % N_REQ; m_phase = 2; m_age = 0;
           end
        1: if (core_done) begin m_key_ok = 1; m_phase = 0; end
           else if (m_age == TIMEOUT - 1) begin m_key_ok = 0; m_phase = 0; end
           else m_age++;
        2: if (core_done) begin
             m_rdata = m_jdata ^ (m_jdec ? dec_mask : enc_mask); m_rerr = 0; m_phase = 3;
           end else if (m_age == TIMEOUT - 1) begin
             m_rdata = '0; m_rerr = 1; m_phase = 3;
           end else m_age++;
        default: if (rsp_ready) begin
             log_id.push_back(int'(rsp_id)); log_data.push_back(rsp_data); m_phase = 0;
           end
      endcase
    end
  end

  task automatic cfg_load(logic [255:0] k, logic [255:0] s);
    cfg_key = k; cfg_seed = s; cfg_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        @(posedge clk); #1 cfg_valid = 1'b0;
        return;
      end
    end
    cfg_valid = 1'b0;
    expired("cfg_accept");
  endtask

  task automatic wait_start(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (core_start) begin at = cyc; return; end
    end
    expired("wait_core_start");
  endtask

  task automatic wait_rsp(output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin at = cyc; return; end
    end
    expired("wait_rsp_valid");
  endtask

  localparam logic [255:0] KEY  = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
  localparam logic [255:0] SEED = {32{8'hA5}};

  initial begin
    int s, r, prev;
    cfg_valid = 0; cfg_key = '0; cfg_seed = '0;
    req_valid = '0; req_data = '0; req_dec = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // No key loaded: requester 0 must be ignored.
    req_valid = 2'b01; req_data[0 +: 128] = 128'h1234;
    repeat (10) begin @(negedge clk); chk("nokey_req_ready", req_ready, 0); end
    chk("nokey_no_start", start_cnt, 0);

    // cfg and pending request together: rekey first, then the job.
    @(posedge clk); #1 lat = 3; enc_mask = 128'hF0;
    cfg_load(KEY, SEED);
    wait_start(s);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(r);
    chk("rekey_core_key", core_key, KEY);
    chk("rekey_core_seed", core_sbox_seed, SEED);
    chk("rekey_one_pulse", rekey_cnt, 1);
    chk("first_job_id", rsp_id, 0);
    chk("first_job_data", rsp_data, 128'h12C4);
    chk("first_job_latency", r - s, 4);

    // Decrypt select on requester 1.
    @(posedge clk); #1 lat = 2; enc_mask = {16{8'hAA}}; dec_mask = {16{8'h55}};
    req_data[128 +: 128] = '0; req_dec = 2'b10; req_valid = 2'b10;
    wait_start(s);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(r);
    chk("dec_data", rsp_data, {16{8'h55}});
    chk("dec_id", rsp_id, 1);
    chk("dec_err", rsp_err, 0);

    // Round-robin with both requesters streaming.
    @(posedge clk); #1 lat = 1; enc_mask = 128'hF0; dec_mask = '0; req_dec = '0;
    req_data[0 +: 128] = 128'h1; req_data[128 +: 128] = 128'h2; req_valid = 2'b11;
    log_id.delete(); log_data.delete();
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(r);
      if (prev >= 0) chk("rr_period_within_k3", (r - prev) <= 5, 1);
      prev = r;
    end
    @(posedge clk); #1 req_valid = '0;
    chk("rr_count", log_id.size(), 4);
    if (log_id.size() == 4) begin
      chk("rr_id0", log_id[0], 0); chk("rr_id1", log_id[1], 1);
      chk("rr_id2", log_id[2], 0); chk("rr_id3", log_id[3], 1);
      chk("rr_data0", log_data[0], 128'hF1); chk("rr_data1", log_data[1], 128'hF2);
    end

    // Job timeout with response backpressure.
    @(posedge clk); #1 lat = -1; rsp_ready = 1'b0; req_data[0 +: 128] = 128'h77; req_valid = 2'b01;
    wait_start(s);
    @(posedge clk); #1 req_valid = '0;
    wait_rsp(r);
    chk("to_cycles", r - s, TIMEOUT);
    repeat (5) begin
      @(negedge clk);
      chk("to_hold_valid", rsp_valid, 1); chk("to_hold_err", rsp_err, 1);
      chk("to_hold_data", rsp_data, 0);   chk("to_hold_id", rsp_id, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;

    // Rekey timeout drops key_ok.
    cfg_load({8{32'hDEADBEEF}}, {8{32'h01234567}});
    repeat (TIMEOUT + 4) @(posedge clk);
    #1 req_valid = 2'b01;
    repeat (5) begin @(negedge clk); chk("rekey_to_blocks_req", req_ready, 0); end
    @(posedge clk); #1 req_valid = '0;

    // Reset in the middle of a job.
    lat = 2;
    cfg_load(KEY, SEED);
    repeat (6) @(posedge clk);
    #1 lat = 20; req_valid = 2'b01;
    wait_start(s);
    @(posedge clk); #1 req_valid = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_core_key", core_key, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1 rst = 1'b1; req_valid = 2'b01;
    repeat (30) begin
      @(negedge clk);
      chk("postrst_req_ready", req_ready, 0);
      chk("postrst_rsp_valid", rsp_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
